// File: rtl/i2cmb_pkg.sv
// Shared definitions for the I2C master-block command sequencer: register map,
// CMDR command codes, CMDR status bit positions and the sequencer state enum.
package i2cmb_pkg;

    localparam logic [1:0] REG_CSR  = 2'd0;
    localparam logic [1:0] REG_DPR  = 2'd1;
    localparam logic [1:0] REG_CMDR = 2'd2;

    localparam logic [2:0] CMD_WRITE    = 3'b001;
    localparam logic [2:0] CMD_READ_ACK = 3'b010;
    localparam logic [2:0] CMD_READ_NAK = 3'b011;
    localparam logic [2:0] CMD_START    = 3'b100;
    localparam logic [2:0] CMD_STOP     = 3'b101;
    localparam logic [2:0] CMD_SET_BUS  = 3'b110;

    localparam int STAT_DON = 7;
    localparam int STAT_NAK = 6;
    localparam int STAT_AL  = 5;
    localparam int STAT_ERR = 4;

    localparam logic [7:0] CSR_ENABLE = 8'hC0;

    localparam logic [1:0] ST_OK  = 2'd0;
    localparam logic [1:0] ST_NAK = 2'd1;
    localparam logic [1:0] ST_AL  = 2'd2;
    localparam logic [1:0] ST_ERR = 2'd3;

    typedef enum logic [3:0] {
        INIT, IDLE, SETBUS, START, ADDR, WR_LOAD, WR_CMD,
        RD_CMD, RD_DPR, WAIT_IRQ, STAT, STOP, DONE
    } state_t;

    // A CMDR readback with no status bit set is treated as an error.
    function automatic logic [1:0] decode_status(input logic [7:0] cmdr);
        if (cmdr[STAT_AL])       return ST_AL;
        else if (cmdr[STAT_ERR]) return ST_ERR;
        else if (cmdr[STAT_NAK]) return ST_NAK;
        else if (cmdr[STAT_DON]) return ST_OK;
        else                     return ST_ERR;
    endfunction

endpackage

// File: rtl/i2cmb_wb_access.sv
// Single Wishbone access engine: latches one request on start_i, holds the bus
// stable until ack_i, then drops cyc/stb and pulses done_o with captured data.
module i2cmb_wb_access #(
    parameter int AW = 2,
    parameter int DW = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic          we_i,
    input  logic [AW-1:0] adr_i,
    input  logic [DW-1:0] wdat_i,
    output logic          done_o,
    output logic [DW-1:0] rdata_o,
    output logic          cyc_o,
    output logic          stb_o,
    output logic          we_o,
    output logic [AW-1:0] adr_o,
    output logic [DW-1:0] dat_o,
    input  logic [DW-1:0] dat_i,
    input  logic          ack_i
);

    logic          r_cyc;
    logic          r_we;
    logic [AW-1:0] r_adr;
    logic [DW-1:0] r_dat;
    logic          r_done;
    logic [DW-1:0] r_rdata;

    // start_i is only honoured while idle, so cyc stays low for at least the
    // cycle in which done_o is high.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cyc   <= 1'b0;
            r_we    <= 1'b0;
            r_adr   <= '0;
            r_dat   <= '0;
            r_done  <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_done <= 1'b0;
            if (r_cyc) begin
                if (ack_i) begin
                    r_cyc   <= 1'b0;
                    r_done  <= 1'b1;
                    r_rdata <= dat_i;
                end
            end else if (start_i) begin
                r_cyc <= 1'b1;
                r_we  <= we_i;
                r_adr <= adr_i;
                r_dat <= wdat_i;
            end
        end
    end

    assign cyc_o   = r_cyc;
    assign stb_o   = r_cyc;
    assign we_o    = r_we;
    assign adr_o   = r_adr;
    assign dat_o   = r_dat;
    assign done_o  = r_done;
    assign rdata_o = r_rdata;

endmodule

// File: rtl/i2cmb_cmd_seq.sv
// Transaction sequencer for an I2C master block: turns one read/write request
// into the set-bus / start / address / data / stop register command sequence.
module i2cmb_cmd_seq
    import i2cmb_pkg::*;
#(
    parameter int WB_ADDR_WIDTH  = 2,
    parameter int WB_DATA_WIDTH  = 8,
    parameter int I2C_ADDR_WIDTH = 7,
    parameter int LEN_WIDTH      = 6
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic                      req_op_i,
    input  logic [3:0]                req_bus_i,
    input  logic [I2C_ADDR_WIDTH-1:0] req_addr_i,
    input  logic [LEN_WIDTH-1:0]      req_len_i,
    input  logic                      wdata_valid_i,
    output logic                      wdata_ready_o,
    input  logic [7:0]                wdata_i,
    output logic                      rdata_valid_o,
    output logic [7:0]                rdata_o,
    output logic                      done_o,
    output logic [1:0]                status_o,
    output logic                      cyc_o,
    output logic                      stb_o,
    output logic                      we_o,
    output logic [WB_ADDR_WIDTH-1:0]  adr_o,
    output logic [WB_DATA_WIDTH-1:0]  dat_o,
    input  logic [WB_DATA_WIDTH-1:0]  dat_i,
    input  logic                      ack_i,
    input  logic                      irq_i,
    output state_t                    dbg_state_o
);

    // Handshakes: req_* is taken on a cycle with req_valid_i & req_ready_o;
    // a write byte is taken on a cycle with wdata_valid_i & wdata_ready_o;
    // rdata_valid_o and done_o are one-cycle pulses with no backpressure.

    state_t                      r_state;
    state_t                      r_cmd_state;
    logic                        r_busy;
    logic                        r_step;
    logic                        r_op;
    logic [3:0]                  r_bus;
    logic [I2C_ADDR_WIDTH-1:0]   r_addr;
    logic [LEN_WIDTH-1:0]        r_cnt;
    logic [7:0]                  r_wbyte;
    logic [1:0]                  r_status;
    logic                        r_rvalid;
    logic [7:0]                  r_rdata;

    logic                        w_acc_req;
    logic                        w_acc_we;
    logic [WB_ADDR_WIDTH-1:0]    w_acc_adr;
    logic [WB_DATA_WIDTH-1:0]    w_acc_dat;
    logic                        w_start;
    logic                        w_done;
    logic [WB_DATA_WIDTH-1:0]    w_rdata;
    logic [1:0]                  w_code;
    logic                        w_last;

    assign w_last = (r_cnt == LEN_WIDTH'(1));

    // Two-access states use r_step: 0 = DPR write, 1 = CMDR write.
    always_comb begin
        w_acc_req = 1'b0;
        w_acc_we  = 1'b1;
        w_acc_adr = WB_ADDR_WIDTH'(REG_CMDR);
        w_acc_dat = '0;
        case (r_state)
            INIT: begin
                w_acc_req = 1'b1;
                w_acc_adr = WB_ADDR_WIDTH'(REG_CSR);
                w_acc_dat = WB_DATA_WIDTH'(CSR_ENABLE);
            end
            SETBUS: begin
                w_acc_req = 1'b1;
                w_acc_adr = r_step ? WB_ADDR_WIDTH'(REG_CMDR) : WB_ADDR_WIDTH'(REG_DPR);
                w_acc_dat = r_step ? WB_DATA_WIDTH'(CMD_SET_BUS) : WB_DATA_WIDTH'(r_bus);
            end
            START: begin
                w_acc_req = 1'b1;
                w_acc_dat = WB_DATA_WIDTH'(CMD_START);
            end
            ADDR: begin
                w_acc_req = 1'b1;
                w_acc_adr = r_step ? WB_ADDR_WIDTH'(REG_CMDR) : WB_ADDR_WIDTH'(REG_DPR);
                w_acc_dat = r_step ? WB_DATA_WIDTH'(CMD_WRITE) : WB_DATA_WIDTH'({r_addr, r_op});
            end
            WR_CMD: begin
                w_acc_req = 1'b1;
                w_acc_adr = r_step ? WB_ADDR_WIDTH'(REG_CMDR) : WB_ADDR_WIDTH'(REG_DPR);
                w_acc_dat = r_step ? WB_DATA_WIDTH'(CMD_WRITE) : WB_DATA_WIDTH'(r_wbyte);
            end
            RD_CMD: begin
                w_acc_req = 1'b1;
                w_acc_dat = w_last ? WB_DATA_WIDTH'(CMD_READ_NAK) : WB_DATA_WIDTH'(CMD_READ_ACK);
            end
            RD_DPR: begin
                w_acc_req = 1'b1;
                w_acc_we  = 1'b0;
                w_acc_adr = WB_ADDR_WIDTH'(REG_DPR);
            end
            STAT: begin
                w_acc_req = 1'b1;
                w_acc_we  = 1'b0;
            end
            STOP: begin
                w_acc_req = 1'b1;
                w_acc_dat = WB_DATA_WIDTH'(CMD_STOP);
            end
            default: ;
        endcase
    end

    assign w_start = w_acc_req & ~r_busy;
    assign w_code  = decode_status(w_rdata[7:0]);

    i2cmb_wb_access #(
        .AW (WB_ADDR_WIDTH),
        .DW (WB_DATA_WIDTH)
    ) u_wb (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (w_start),
        .we_i    (w_acc_we),
        .adr_i   (w_acc_adr),
        .wdat_i  (w_acc_dat),
        .done_o  (w_done),
        .rdata_o (w_rdata),
        .cyc_o   (cyc_o),
        .stb_o   (stb_o),
        .we_o    (we_o),
        .adr_o   (adr_o),
        .dat_o   (dat_o),
        .dat_i   (dat_i),
        .ack_i   (ack_i)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= INIT;
            r_cmd_state <= INIT;
            r_busy      <= 1'b0;
            r_step      <= 1'b0;
            r_op        <= 1'b0;
            r_bus       <= '0;
            r_addr      <= '0;
            r_cnt       <= '0;
            r_wbyte     <= '0;
            r_status    <= ST_OK;
            r_rvalid    <= 1'b0;
            r_rdata     <= '0;
        end else begin
            r_rvalid <= 1'b0;
            if (w_start) r_busy <= 1'b1;
            case (r_state)
                INIT: if (w_done) begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                IDLE: if (req_valid_i) begin
                    r_op     <= req_op_i;
                    r_bus    <= req_bus_i;
                    r_addr   <= req_addr_i;
                    r_cnt    <= req_len_i;
                    r_status <= ST_OK;
                    r_step   <= 1'b0;
                    r_state  <= SETBUS;
                end
                SETBUS, ADDR, WR_CMD: if (w_done) begin
                    r_busy <= 1'b0;
                    r_step <= ~r_step;
                    if (r_step) begin
                        r_cmd_state <= r_state;
                        r_state     <= WAIT_IRQ;
                    end
                end
                START, RD_CMD, STOP: if (w_done) begin
                    r_busy      <= 1'b0;
                    r_cmd_state <= r_state;
                    r_state     <= WAIT_IRQ;
                end
                WR_LOAD: if (wdata_valid_i) begin
                    r_wbyte <= wdata_i;
                    r_state <= WR_CMD;
                end
                WAIT_IRQ: if (irq_i) r_state <= STAT;
                STAT: if (w_done) begin
                    r_busy <= 1'b0;
                    if (r_cmd_state == STOP) begin
                        // A failure already recorded outranks the stop's own result.
                        r_status <= (r_status != ST_OK) ? r_status : w_code;
                        r_state  <= DONE;
                    end else if (w_code == ST_AL) begin
                        r_status <= ST_AL;
                        r_state  <= DONE;
                    end else if (w_code != ST_OK) begin
                        r_status <= w_code;
                        r_state  <= STOP;
                    end else begin
                        case (r_cmd_state)
                            SETBUS:  r_state <= START;
                            START:   r_state <= ADDR;
                            ADDR: begin
                                if (r_cnt == '0) r_state <= STOP;
                                else if (r_op)   r_state <= RD_CMD;
                                else             r_state <= WR_LOAD;
                            end
                            WR_CMD: begin
                                r_cnt   <= r_cnt - LEN_WIDTH'(1);
                                r_state <= w_last ? STOP : WR_LOAD;
                            end
                            RD_CMD:  r_state <= RD_DPR;
                            default: r_state <= STOP;
                        endcase
                    end
                end
                RD_DPR: if (w_done) begin
                    r_busy   <= 1'b0;
                    r_rvalid <= 1'b1;
                    r_rdata  <= w_rdata[7:0];
                    r_cnt    <= r_cnt - LEN_WIDTH'(1);
                    r_state  <= w_last ? STOP : RD_CMD;
                end
                DONE:    r_state <= IDLE;
                default: r_state <= INIT;
            endcase
        end
    end

    assign req_ready_o   = (r_state == IDLE);
    assign wdata_ready_o = (r_state == WR_LOAD);
    assign done_o        = (r_state == DONE);
    assign status_o      = (r_state == DONE) ? r_status : ST_OK;
    assign rdata_valid_o = r_rvalid;
    assign rdata_o       = r_rdata;
    assign dbg_state_o   = r_state;

endmodule

// File: doc/i2cmb_cmd_seq.md
I2CMB_CMD_SEQ -- requirements
Module: i2cmb_cmd_seq

Interface
REQ-001 SHALL have parameter WB_ADDR_WIDTH, default 2, Wishbone register address width.
REQ-002 SHALL have parameter WB_DATA_WIDTH, default 8, Wishbone data width.
REQ-003 SHALL have parameter I2C_ADDR_WIDTH, default 7, I2C slave address width.
REQ-004 SHALL have parameter LEN_WIDTH, default 6, byte-count width.
REQ-005 SHALL use one clock and a synchronous, active-high reset; all logic is on the rising edge of clk_i.
REQ-006 SHALL have these ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- req_valid_i  in  1  transaction request
- req_ready_o  out  1  sequencer can accept a request
- req_op_i  in  1  0 = write, 1 = read
- req_bus_i  in  4  I2C bus ID
- req_addr_i  in  I2C_ADDR_WIDTH  slave address
- req_len_i  in  LEN_WIDTH  byte count; 0 = address-only
- wdata_valid_i / wdata_ready_o / wdata_i  in / out / in  1 / 1 / 8  write-byte stream
- rdata_valid_o / rdata_o  out  1 / 8  read-byte pulse; no backpressure
- done_o  out  1  one-cycle end-of-transaction pulse
- status_o  out  2  0 = OK, 1 = NAK, 2 = arbitration lost, 3 = error; valid with done_o
- cyc_o, stb_o, we_o  out  1  Wishbone master controls
- adr_o  out  WB_ADDR_WIDTH  register select
- dat_o  out  WB_DATA_WIDTH  write data
- dat_i  in  WB_DATA_WIDTH  read data
- ack_i  in  1  Wishbone acknowledge
- irq_i  in  1  controller interrupt

Function
REQ-007 SHALL address controller registers as CSR = 0, DPR = 1, CMDR = 2; CMDR codes: write 3'b001, read-ack 3'b010, read-nak 3'b011, start 3'b100, stop 3'b101, set-bus 3'b110.
REQ-008 Each Wishbone access SHALL hold cyc_o, stb_o, we_o, adr_o and dat_o stable until ack_i, then drop cyc_o and stb_o for at least one cycle.
REQ-009 Read accesses SHALL capture dat_i in the ack_i cycle.
REQ-010 After reset, the first action SHALL be writing CSR = 8'hC0 (enable + IE); req_ready_o SHALL stay 0 until that access is acked.
REQ-011 req_ready_o SHALL be 1 only in IDLE; a request is accepted when req_valid_i and req_ready_o are both 1, and all req_* fields are latched in that cycle.
REQ-012 Transaction order SHALL be:
- DPR = bus, CMDR = set-bus
- CMDR = start
- DPR = {addr, op}, CMDR = write
- for write: per byte, DPR = wdata, CMDR = write
- for read: per byte, CMDR = read-ack (last byte read-nak), then read DPR
- CMDR = stop, then DONE
REQ-013 After every CMDR command write, the FSM SHALL enter WAIT_IRQ until irq_i = 1, then read CMDR to clear the interrupt and decode its bits: DON = 7, NAK = 6, AL = 5, ERR = 4.
REQ-014 When the decoded status is DON, the sequence SHALL continue.
REQ-015 When NAK is set, the FSM SHALL issue stop and finish with status 1.
REQ-016 When AL is set, the FSM SHALL go to DONE without stop, status 2.
REQ-017 When ERR is set, the FSM SHALL issue stop, status 3.
REQ-018 If several status bits are set, priority SHALL be AL > ERR > NAK > DON.
REQ-019 wdata_ready_o SHALL be 1 only in the WR_LOAD state; the DPR write is not started until a wdata_valid_i/wdata_ready_o handshake occurs.
REQ-020 rdata_valid_o SHALL pulse for one cycle on the ack of each DPR read, with rdata_o = captured byte.
REQ-021 The byte counter SHALL decrement per completed byte; the last byte is the one where the counter equals 1.
REQ-022 With req_len_i = 0, the sequence SHALL be set-bus, start, address, stop.
REQ-023 FSM states SHALL be: INIT, IDLE, SETBUS, START, ADDR, WR_LOAD, WR_CMD, RD_CMD, RD_DPR, WAIT_IRQ, STAT, STOP, DONE.
REQ-024 done_o SHALL pulse exactly once per accepted request, in the DONE cycle; the FSM returns to IDLE on the next cycle.

Reset
REQ-025 While rst_i = 1, all outputs SHALL be 0, the FSM SHALL be in INIT, and counters and latches SHALL be cleared.
REQ-026 Reset asserted mid-transaction SHALL abort it with no done_o, and Wishbone signals drop on the next edge.

Structure
REQ-027 Register offsets, CMDR codes, status bit indices, CSR enable value and the state enum SHALL live in i2cmb_pkg.
REQ-028 One sub-module, i2cmb_wb_access, SHALL implement the single-access Wishbone handshake of REQ-008 and REQ-009 (start/done/rdata).

Verification
REQ-029 After reset release, the bench SHALL check a CSR write of C0 and that req_ready_o rises only after its ack.
REQ-030 Write: bus 0, addr 0x22, len 2, data 78, 79 -> DPR writes 00, 44, 78, 79; CMDR 06, 04, 01, 01, 01, 05; done_o with status 0.
REQ-031 Read: addr 0x22, len 3, model returns 64, 65, 66 -> DPR 45; CMDR 02, 02, 03, 05; three rdata pulses 64, 65, 66.
REQ-032 NAK: the model returns CMDR = 40 after the address write -> next command is stop (05); status 1; no data bytes sent.
REQ-033 AL: CMDR = 20 after start -> no stop is issued; status 2; req_ready_o is 1 two cycles later.
REQ-034 Backpressure: wdata_valid_i held low for 50 cycles -> no Wishbone activity during that time; then the write proceeds normally.
REQ-035 Reset during WAIT_IRQ of byte 1 -> cyc_o is 0 next cycle, no done_o, and after reset the CSR init repeats.
